sram_io_dump: RTL and testbench
===============================

// Module: sram_io_dump
// PURPOSE
//   Read-back counterpart of the serial SRAM loader. On START it reads LEN words from SRAM,
//   beginning at ADDR_I, and shifts each word out LSB-first on SO with a valid/ready handshake.
//   Sits between the instruction/data SRAM and the external test port. Lets the host dump memory.
// PARAMETERS
//   MEMORY_DATA_WIDTH  8  SRAM word width in bits
//   MEMORY_ADDR_WIDTH  9  SRAM address width in bits
// PORTS
//   CLK     in   1      clock; all logic on posedge
//   RST     in   1      synchronous reset, active-high
//   START   in   1      start request; sampled in IDLE or DONE only
//   ADDR_I  in   AW     start address; captured when START is accepted
//   LEN_I   in   AW+1   word count, 0..2**AW; captured when START is accepted
//   PI      in   DW     SRAM read data; valid the cycle after CEN=1
//   SO_RDY  in   1      receiver accepts the current SO bit
//   CEN     out  1      SRAM chip enable, active-high
//   D_WE    out  1      SRAM write enable; constant 0 (tied for the shared SRAM bus mux)
//   A       out  AW     SRAM address; equals the address register while CEN=1, else 0
//   SO      out  1      serial data out
//   SO_VLD  out  1      SO holds a valid bit
//   BUSY    out  1      high in READ/CAPT/SHIFT
//   RDY     out  1      dump complete; sticky in DONE
// BEHAVIOUR
//   Reset values (RST=1 at an edge): state=IDLE; CEN, D_WE, A, SO, SO_VLD, BUSY, RDY = 0.
//     Registers addr, remaining count, shift reg and bit count = 0.
//   FSM: IDLE -> READ -> CAPT -> SHIFT -> (READ | DONE); DONE -> READ | DONE.
//   IDLE : START=1 -> capture ADDR_I and LEN_I. LEN_I=0 -> DONE; otherwise -> READ.
//   READ : CEN=1, A=addr; exactly one cycle; -> CAPT.
//   CAPT : load PI into the shift reg; bitcnt=NB-1, where NB=DW (or DW+1 with parity);
//          decrement remaining; -> SHIFT.
//   SHIFT: SO=sreg[0], SO_VLD=1. On an edge with SO_RDY=1: shift right and decrement bitcnt.
//          On the accepting edge of the last bit (bitcnt=0):
//          remaining!=0 -> addr<=addr+1, -> READ; remaining==0 -> DONE.
//          SO_RDY=0 -> hold SO and the state indefinitely. SO_VLD is never withdrawn while unaccepted.
//   DONE : RDY=1 until RST or an accepted START. START in DONE restarts exactly as from IDLE.
//   Timing: START is accepted at edge 0.
//     CEN=1 in cycle 1. First SO_VLD in cycle 3. Per-word overhead is 2 cycles (READ, CAPT).
//   With SO_RDY tied high, a word costs NB+2 cycles.
//     Total from accept to RDY=1 = LEN*(NB+2)+1 cycles.
//   Address increment wraps modulo 2**AW (addr 2**AW-1 -> 0). LEN=2**AW dumps the whole SRAM.
//   START while BUSY=1 is ignored; it does not alter the address, count or data stream.
//   RST takes priority over all events, including mid-word. Next cycle is IDLE with reset outputs.
//     The partial word is discarded and no SRAM access completes.
//   SO is 0 whenever SO_VLD=0.
//   CEN, A and SO are registered/state-decoded. There is no combinational path from inputs to outputs.
// CONFIGURATION
//   SRAM_DUMP_PARITY_EN defined:
//     NB=DW+1. An even-parity bit (XOR of the DW data bits) follows the MSB of each word
//     as its last serial bit.
//   Undefined: NB=DW. No parity bit. Port list is identical in both builds.
// TESTING
//   T1: RST; ADDR_I=0x010, LEN_I=1, SRAM[0x010]=0xA5, SO_RDY=1.
//       Expect CEN=1/A=0x010 for 1 cycle, then SO=1,0,1,0,0,1,0,1.
//       RDY=1 exactly 1+10 cycles after accept.
//   T2: ADDR_I=0x1FF, LEN_I=3, SRAM[0x1FF,0x000,0x001]=0x11,0x22,0x33.
//       Expect A sequence 0x1FF,0x000,0x001 and a 24-bit stream equal to those bytes, LSB-first.
//   T3: LEN_I=2 with SO_RDY toggled randomly (including 5-cycle stalls).
//       Expect SO held stable while SO_RDY=0, no bit lost or duplicated, RDY after the 16th accepted bit.
//   T4: LEN_I=0 -> no CEN pulse; RDY=1 one cycle after accept.
//       Then START with LEN_I=1 from DONE -> RDY drops, a new dump is performed.
//   T5: LEN_I=4; assert RST during bit 3 of word 2.
//       Expect all outputs 0 the next cycle, state IDLE, and no further CEN.
//       START pulses during BUSY are ignored.
//   T6 (SRAM_DUMP_PARITY_EN): SRAM word 0x07.
//       Expect 9 bits 1,1,1,0,0,0,0,0 then parity 1. Word 0x03 -> parity 0.

Source files
------------

// File: rtl/sram_io_dump.sv
// sram_io_dump: reads LEN words from the SRAM, starting at a given address, and
// streams each word out LSB-first on a serial valid/ready port so the host can
// dump memory contents.
//
// Optional build macro: SRAM_DUMP_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits) is appended after
//   the MSB of every word, so each word becomes DW+1 serial bits. The port list
//   is the same in both builds.
//
// Timing with SO_RDY held high: START is accepted at edge 0, CEN is high in
// cycle 1, and the first SO_VLD appears in cycle 3. Each word costs NB+2
// cycles (READ, CAPT, then NB shift cycles). RDY rises LEN*(NB+2)+1 cycles
// after the accept.
module sram_io_dump #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_I,
    input  logic [MEMORY_ADDR_WIDTH:0]   LEN_I,
    input  logic [MEMORY_DATA_WIDTH-1:0] PI,
    input  logic                         SO_RDY,
    output logic                         CEN,
    output logic                         D_WE,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic                         SO,
    output logic                         SO_VLD,
    output logic                         BUSY,
    output logic                         RDY
);

    localparam int DW = MEMORY_DATA_WIDTH;
    localparam int AW = MEMORY_ADDR_WIDTH;

`ifdef SRAM_DUMP_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    // Bit counter only needs to hold NB-1 (index of the last serial bit).
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(NB - 1);
    localparam logic [BW-1:0] BIT_STEP  = 1;
    localparam logic [AW-1:0] ADDR_STEP = 1;
    localparam logic [AW:0]   LEN_STEP  = 1;

    // Dump FSM states.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] CAPT  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] addr;
    logic [AW:0]   remaining;
    logic [NB-1:0] sreg;
    logic [BW-1:0] bitcnt;
    logic [NB-1:0] load_word;

    // Word as it enters the shift register; parity (if built in) sits above
    // the MSB so it leaves last.
`ifdef SRAM_DUMP_PARITY_EN
    assign load_word = {^PI, PI};
`else
    assign load_word = PI;
`endif

    // Main sequencer: address/count capture, SRAM read, capture and serialisation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            sreg      <= '0;
            bitcnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        addr      <= ADDR_I;
                        remaining <= LEN_I;
                        state     <= (LEN_I == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    sreg      <= load_word;
                    bitcnt    <= LAST_BIT;
                    remaining <= remaining - LEN_STEP;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (SO_RDY) begin
                        sreg <= {1'b0, sreg[NB-1:1]};
                        if (bitcnt == '0) begin
                            if (remaining != '0) begin
                                addr  <= addr + ADDR_STEP;
                                state <= READ;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            bitcnt <= bitcnt - BIT_STEP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state, so no input reaches
    // an output combinationally. The SRAM is only ever read here.
    assign CEN    = (state == READ);
    assign D_WE   = 1'b0;
    assign A      = CEN ? addr : '0;
    assign SO_VLD = (state == SHIFT);
    assign SO     = SO_VLD & sreg[0];
    assign BUSY   = (state == READ) || (state == CAPT) || (state == SHIFT);
    assign RDY    = (state == DONE);

endmodule

// File: tb/tb_sram_io_dump.sv
// tb_sram_io_dump: scoreboard bench for sram_io_dump. Stimulus pushes the
// expected SRAM addresses and serial bits into queues; a monitor on the
// falling clock edge pops and compares whenever the DUT reads the SRAM or a
// serial bit is accepted. Build with SRAM_DUMP_PARITY_EN to exercise parity.
module tb_sram_io_dump;

`ifdef SRAM_DUMP_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [8:0] ADDR_I = '0;
    logic [9:0] LEN_I = '0;
    logic [7:0] PI = '0;
    logic       SO_RDY = 1'b1;
    logic       CEN, D_WE, SO, SO_VLD, BUSY, RDY;
    logic [8:0] A;

    logic [7:0] mem [0:511];

    logic       exp_bits [$];
    logic [8:0] exp_addr [$];
    int         checks = 0;
    int         passed = 0;
    int         accepted = 0;
    bit         mon_en = 1'b0;
    bit         stall_prev = 1'b0;
    logic       so_prev = 1'b0;
    int         cnt;
    int         acc_start;

    // Stall pattern for the handshake test; bits 8:4 give a 5-cycle stall.
    logic [31:0] rdy_pat = 32'hD6CB7E0F;

    sram_io_dump #(
        .MEMORY_DATA_WIDTH(8),
        .MEMORY_ADDR_WIDTH(9)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .ADDR_I(ADDR_I),
        .LEN_I (LEN_I),
        .PI    (PI),
        .SO_RDY(SO_RDY),
        .CEN   (CEN),
        .D_WE  (D_WE),
        .A     (A),
        .SO    (SO),
        .SO_VLD(SO_VLD),
        .BUSY  (BUSY),
        .RDY   (RDY)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Synchronous SRAM model: data appears the cycle after CEN.
    always @(posedge CLK) begin
        if (CEN) PI <= mem[A];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    // Monitor: SRAM accesses, accepted bits, stall stability and quiet outputs.
    always @(negedge CLK) begin
        if (mon_en) begin
            check_output("quiet_outputs", {D_WE, (CEN ? 9'd0 : A), (SO_VLD ? 1'b0 : SO)}, 32'd0);
            if (CEN && !RST) begin
                check_output("cen_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check_output("sram_addr", A, exp_addr.pop_front());
            end
            if (stall_prev) begin
                check_output("stall_vld_held", SO_VLD, 1);
                check_output("stall_so_held", SO, so_prev);
            end
            stall_prev = SO_VLD && !SO_RDY && !RST;
            so_prev    = SO;
            if (SO_VLD && SO_RDY && !RST) begin
                accepted++;
                check_output("bit_expected", exp_bits.size() != 0, 1);
                if (exp_bits.size() != 0) check_output("so_bit", SO, exp_bits.pop_front());
            end
        end
    end

    task automatic push_bits(input logic [8:0] bits, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(bits[i]);
    endtask

    task automatic push_word(input logic [8:0] addr, input logic [7:0] data);
        mem[addr] = data;
        exp_addr.push_back(addr);
        push_bits({1'b0, data}, 8);
`ifdef SRAM_DUMP_PARITY_EN
        exp_bits.push_back(^data);
`endif
    endtask

    // Issue a START; returns one step into cycle 1 after the accepting edge.
    task automatic apply_stimulus(input logic [8:0] addr, input logic [9:0] len);
        @(posedge CLK); #1;
        START  = 1'b1;
        ADDR_I = addr;
        LEN_I  = len;
        @(posedge CLK); #1;
        START  = 1'b0;
    endtask

    // Count cycles after the accept until RDY; optionally drive a stall pattern.
    task automatic wait_rdy(input bit stall, output int n);
        n = 1;
        while (RDY !== 1'b1 && n < 400) begin
            if (stall) SO_RDY = rdy_pat[n % 32];
            @(posedge CLK); #1;
            n++;
        end
        SO_RDY = 1'b1;
        check_output("rdy_reached", RDY, 1);
    endtask

    task automatic end_test(input string name);
        check_output({name, "_bits_left"}, exp_bits.size(), 0);
        check_output({name, "_addr_left"}, exp_addr.size(), 0);
        exp_bits.delete();
        exp_addr.delete();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence.
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_output("reset_outputs", {CEN, D_WE, A, SO, SO_VLD, BUSY, RDY}, 32'd0);
        RST = 1'b0;
        mon_en = 1'b1;

        // T1: single word 0xA5 -> 1,0,1,0,0,1,0,1
        push_word(9'h010, 8'hA5);
        apply_stimulus(9'h010, 10'd1);
        check_output("t1_busy", BUSY, 1);
        wait_rdy(1'b0, cnt);
        check_output("t1_rdy_cycles", cnt, 1 * (NB + 2) + 1);
        check_output("t1_done_flags", {BUSY, RDY}, 2'b01);
        end_test("t1");

        // T2: address wrap 0x1FF -> 0x000 -> 0x001
        push_word(9'h1FF, 8'h11);
        push_word(9'h000, 8'h22);
        push_word(9'h001, 8'h33);
        apply_stimulus(9'h1FF, 10'd3);
        wait_rdy(1'b0, cnt);
        check_output("t2_rdy_cycles", cnt, 3 * (NB + 2) + 1);
        end_test("t2");

        // T3: two words under a stalling receiver
        push_word(9'h020, 8'h5C);
        push_word(9'h021, 8'hE3);
        acc_start = accepted;
        apply_stimulus(9'h020, 10'd2);
        wait_rdy(1'b1, cnt);
        check_output("t3_accepted_bits", accepted - acc_start, 2 * NB);
        end_test("t3");

        // T4: zero length, then restart from DONE
        apply_stimulus(9'h030, 10'd0);
        wait_rdy(1'b0, cnt);
        check_output("t4_zero_len_cycles", cnt, 1);
        push_word(9'h031, 8'h96);
        apply_stimulus(9'h031, 10'd1);
        check_output("t4_rdy_drop", RDY, 0);
        wait_rdy(1'b0, cnt);
        check_output("t4_restart_cycles", cnt, 1 * (NB + 2) + 1);
        end_test("t4");

        // T5: reset during bit 3 of word 2; ignored START while busy
        mem[9'h040] = 8'h3C;
        mem[9'h041] = 8'hC3;
        mem[9'h042] = 8'h0F;
        mem[9'h043] = 8'hF0;
        exp_addr.push_back(9'h040);
        exp_addr.push_back(9'h041);
        push_bits(9'h03C, NB);
        push_bits(9'h003, 3);
        apply_stimulus(9'h040, 10'd4);
        repeat (4) @(posedge CLK);
        #1;
        START = 1'b1; ADDR_I = 9'h100; LEN_I = 10'd0;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (NB + 2) @(posedge CLK);
        #1;
        check_output("t5_mid_word_vld", SO_VLD, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_output("t5_reset_outputs", {CEN, D_WE, A, SO, SO_VLD, BUSY, RDY}, 32'd0);
        RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check_output("t5_still_idle", {CEN, BUSY, RDY}, 3'b000);
        end_test("t5");

`ifdef SRAM_DUMP_PARITY_EN
        // T6: parity words 0x07 (parity 1) and 0x03 (parity 0)
        mem[9'h050] = 8'h07;
        mem[9'h051] = 8'h03;
        exp_addr.push_back(9'h050);
        exp_addr.push_back(9'h051);
        push_bits(9'b1_0000_0111, 9);
        push_bits(9'b0_0000_0011, 9);
        apply_stimulus(9'h050, 10'd2);
        wait_rdy(1'b0, cnt);
        check_output("t6_rdy_cycles", cnt, 2 * 11 + 1);
        end_test("t6");
`endif

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
